audio_sample_sequencer: RTL and testbench

Sequences one stereo sample at a time from the audio codec's ADC FIFO, through an external effects stage, and into the codec's DAC FIFO. It replaces free-running read/write glue with a read → process → write state machine. The state machine has a processing watchdog with raw-sample fallback, a bypass mode, and status counters. It sits between `audio_codec` and the effects datapath in the top level, on the same clock domain.

---
 rtl/audio_seq_pkg.sv | 19 +
 rtl/audio_seq_watchdog.sv | 30 +++
 rtl/audio_sample_sequencer.sv | 166 ++++++++++++++++
 tb/tb_audio_sample_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared types for the audio sample sequencer: FSM states, default sample
// width and the stereo sample container used between codec and effects.
package audio_seq_pkg;

  localparam int SAMPLE_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PROC_REQ  = 2'd1,
    ST_PROC_WAIT = 2'd2,
    ST_WRITE     = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_seq_watchdog.sv
// Processing watchdog: counts cycles spent waiting for the effects stage and
// flags expiry once TIMEOUT cycles have elapsed since the last clear.
module audio_seq_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Holds at the expiry value so a stalled count can never wrap back to zero.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/audio_sample_sequencer.sv
// Read -> process -> write sequencer between the codec FIFOs and the effects
// stage, with watchdog fallback to the raw sample, bypass and status counters.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                bypass,
  input  logic                read_ready,
  input  logic [SAMPLE_W-1:0] readdata_left,
  input  logic [SAMPLE_W-1:0] readdata_right,
  output logic                read,
  input  logic                write_ready,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic                write,
  output logic                proc_valid,
  output logic [SAMPLE_W-1:0] proc_left,
  output logic [SAMPLE_W-1:0] proc_right,
  input  logic                proc_ready,
  input  logic                res_valid,
  input  logic [SAMPLE_W-1:0] res_left,
  input  logic [SAMPLE_W-1:0] res_right,
  output logic                busy,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    timeout_cnt,
  output seq_state_t          dbg_state
);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_t;

  seq_state_t r_state;
  seq_state_t w_next_state;

  sample_t r_raw;
  sample_t r_wdata;
  logic    r_read;
  logic    r_write;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_timeout_cnt;

  logic w_start;
  logic w_load_bypass;
  logic w_wd_clear;
  logic w_wd_count;
  logic w_wd_expired;
  logic w_load_res;
  logic w_fallback;
  logic w_do_write;

  // Handshakes: proc_valid/proc_ready and res_valid transfer on the rising
  // edge where both sides are high; the codec side uses read_ready/write_ready
  // as the qualifier and gets a registered one-cycle read/write pulse back.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_load_bypass = 1'b0;
    w_wd_clear    = 1'b0;
    w_wd_count    = 1'b0;
    w_load_res    = 1'b0;
    w_fallback    = 1'b0;
    w_do_write    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && read_ready) begin
          w_start       = 1'b1;
          w_load_bypass = bypass;
          w_next_state  = bypass ? ST_WRITE : ST_PROC_REQ;
        end
      end
      ST_PROC_REQ: begin
        if (proc_ready) begin
          w_wd_clear   = 1'b1;
          w_next_state = ST_PROC_WAIT;
        end
      end
      ST_PROC_WAIT: begin
        w_wd_count = 1'b1;
        // A result arriving on the expiry edge takes priority over fallback.
        if (res_valid) begin
          w_load_res   = 1'b1;
          w_next_state = ST_WRITE;
        end else if (w_wd_expired) begin
          w_fallback   = 1'b1;
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (write_ready) begin
          w_do_write   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  audio_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .i_clear    (w_wd_clear),
    .i_count_en (w_wd_count),
    .o_expired  (w_wd_expired)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_raw         <= '0;
      r_wdata       <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_sample_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_read  <= w_start;
      r_write <= w_do_write;
      if (w_start) begin
        r_raw <= '{left: readdata_left, right: readdata_right};
      end
      if (w_load_bypass) begin
        r_wdata <= '{left: readdata_left, right: readdata_right};
      end else if (w_load_res) begin
        r_wdata <= '{left: res_left, right: res_right};
      end else if (w_fallback) begin
        r_wdata <= r_raw;
      end
      if (w_do_write) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
      if (w_fallback && !(&r_timeout_cnt)) begin
        r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
      end
    end
  end

  assign read            = r_read;
  assign write           = r_write;
  assign writedata_left  = r_wdata.left;
  assign writedata_right = r_wdata.right;
  assign proc_valid      = (r_state == ST_PROC_REQ);
  assign proc_left       = r_raw.left;
  assign proc_right      = r_raw.right;
  assign busy            = (r_state != ST_IDLE);
  assign sample_cnt      = r_sample_cnt;
  assign timeout_cnt     = r_timeout_cnt;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer with a short watchdog and narrow
// counters so saturation is reachable quickly.
module tb_audio_sample_sequencer;
  import audio_seq_pkg::*;

  localparam int SW = 24;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          CLOCK_50;
  logic          reset;
  logic          enable;
  logic          bypass;
  logic          read_ready;
  logic [SW-1:0] readdata_left;
  logic [SW-1:0] readdata_right;
  logic          read;
  logic          write_ready;
  logic [SW-1:0] writedata_left;
  logic [SW-1:0] writedata_right;
  logic          write;
  logic          proc_valid;
  logic [SW-1:0] proc_left;
  logic [SW-1:0] proc_right;
  logic          proc_ready;
  logic          res_valid;
  logic [SW-1:0] res_left;
  logic [SW-1:0] res_right;
  logic          busy;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] timeout_cnt;
  seq_state_t    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_writes = 0;
  int reads_before;
  int writes_before;
  int exp_to;

  audio_sample_sequencer #(
    .SAMPLE_W (SW),
    .CNT_W    (CW),
    .TIMEOUT  (TO)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .enable          (enable),
    .bypass          (bypass),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write_ready     (write_ready),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .write           (write),
    .proc_valid      (proc_valid),
    .proc_left       (proc_left),
    .proc_right      (proc_right),
    .proc_ready      (proc_ready),
    .res_valid       (res_valid),
    .res_left        (res_left),
    .res_right       (res_right),
    .busy            (busy),
    .sample_cnt      (sample_cnt),
    .timeout_cnt     (timeout_cnt),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (read === 1'b1) n_reads++;
    if (write === 1'b1) n_writes++;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, 64'(read), 64'd0);
    chk({tag, "_write"}, 64'(write), 64'd0);
    chk({tag, "_wdl"}, 64'(writedata_left), 64'd0);
    chk({tag, "_wdr"}, 64'(writedata_right), 64'd0);
    chk({tag, "_pvalid"}, 64'(proc_valid), 64'd0);
    chk({tag, "_pl"}, 64'(proc_left), 64'd0);
    chk({tag, "_pr"}, 64'(proc_right), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_scnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, "_tcnt"}, 64'(timeout_cnt), 64'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; bypass = 1'b0; read_ready = 1'b0;
    readdata_left = '0; readdata_right = '0; write_ready = 1'b0;
    proc_ready = 1'b0; res_valid = 1'b0; res_left = '0; res_right = '0;

    // reset state
    tick(); tick();
    chk_all_zero("rst");
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    tick();

    // bypass
    enable = 1'b1; bypass = 1'b1; read_ready = 1'b1; write_ready = 1'b1;
    readdata_left = 24'h123456; readdata_right = 24'hABCDEF;
    tick();
    chk("byp_read", 64'(read), 64'd1);
    chk("byp_write0", 64'(write), 64'd0);
    chk("byp_state", 64'(dbg_state), 64'(ST_WRITE));
    chk("byp_wdl_early", 64'(writedata_left), 64'h123456);
    enable = 1'b0; read_ready = 1'b0; readdata_left = '0; readdata_right = '0;
    tick();
    chk("byp_read_off", 64'(read), 64'd0);
    chk("byp_write", 64'(write), 64'd1);
    chk("byp_wdl", 64'(writedata_left), 64'h123456);
    chk("byp_wdr", 64'(writedata_right), 64'hABCDEF);
    chk("byp_scnt", 64'(sample_cnt), 64'd1);
    tick();
    chk("byp_write_off", 64'(write), 64'd0);
    chk("byp_busy", 64'(busy), 64'd0);

    // processed path with delayed proc_ready
    enable = 1'b1; bypass = 1'b0; read_ready = 1'b1;
    readdata_left = 24'h111111; readdata_right = 24'h222222;
    tick();
    chk("proc_read", 64'(read), 64'd1);
    chk("proc_valid", 64'(proc_valid), 64'd1);
    enable = 1'b0; read_ready = 1'b0; readdata_left = 24'h999999; readdata_right = 24'h999999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("proc_hold_valid", 64'(proc_valid), 64'd1);
      chk("proc_hold_l", 64'(proc_left), 64'h111111);
      chk("proc_hold_r", 64'(proc_right), 64'h222222);
    end
    proc_ready = 1'b1;
    tick();
    chk("proc_wait_state", 64'(dbg_state), 64'(ST_PROC_WAIT));
    chk("proc_valid_off", 64'(proc_valid), 64'd0);
    proc_ready = 1'b0;
    tick();
    res_valid = 1'b1; res_left = 24'h000001; res_right = 24'h000002;
    tick();
    res_valid = 1'b0; res_left = 24'h555555; res_right = 24'h555555;
    chk("proc_to_write", 64'(dbg_state), 64'(ST_WRITE));
    chk("proc_wdl", 64'(writedata_left), 64'h000001);
    chk("proc_wdr", 64'(writedata_right), 64'h000002);
    tick();
    chk("proc_write", 64'(write), 64'd1);
    chk("proc_scnt", 64'(sample_cnt), 64'd2);
    chk("proc_tcnt", 64'(timeout_cnt), 64'd0);

    // watchdog fallback after exactly TO cycles in PROC_WAIT
    proc_ready = 1'b1; enable = 1'b1; read_ready = 1'b1;
    readdata_left = 24'hA5A5A5; readdata_right = 24'h5A5A5A;
    tick();
    enable = 1'b0; read_ready = 1'b0;
    tick();
    chk("wd_enter", 64'(dbg_state), 64'(ST_PROC_WAIT));
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("wd_waiting", 64'(dbg_state), 64'(ST_PROC_WAIT));
    end
    tick();
    chk("wd_fire_state", 64'(dbg_state), 64'(ST_WRITE));
    chk("wd_tcnt", 64'(timeout_cnt), 64'd1);
    chk("wd_wdl", 64'(writedata_left), 64'hA5A5A5);
    chk("wd_wdr", 64'(writedata_right), 64'h5A5A5A);
    tick();
    chk("wd_write", 64'(write), 64'd1);
    chk("wd_scnt", 64'(sample_cnt), 64'd3);

    // result arriving on the timeout edge wins
    enable = 1'b1; read_ready = 1'b1;
    readdata_left = 24'h777777; readdata_right = 24'h888888;
    tick();
    enable = 1'b0; read_ready = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    res_valid = 1'b1; res_left = 24'h0000AA; res_right = 24'h0000BB;
    tick();
    res_valid = 1'b0;
    chk("col_state", 64'(dbg_state), 64'(ST_WRITE));
    chk("col_wdl", 64'(writedata_left), 64'h0000AA);
    chk("col_wdr", 64'(writedata_right), 64'h0000BB);
    chk("col_tcnt", 64'(timeout_cnt), 64'd1);
    tick();
    chk("col_scnt", 64'(sample_cnt), 64'd4);

    // back-pressure on the DAC side
    write_ready = 1'b0; bypass = 1'b1; enable = 1'b1; read_ready = 1'b1;
    readdata_left = 24'hC0FFEE; readdata_right = 24'h00BEEF;
    tick();
    chk("bp_read", 64'(read), 64'd1);
    readdata_left = 24'h314159; readdata_right = 24'h271828;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_no_read", 64'(read), 64'd0);
      chk("bp_no_write", 64'(write), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_wdl", 64'(writedata_left), 64'hC0FFEE);
    end
    write_ready = 1'b1; enable = 1'b0;
    tick();
    chk("bp_write", 64'(write), 64'd1);
    chk("bp_wdr", 64'(writedata_right), 64'h00BEEF);
    chk("bp_scnt", 64'(sample_cnt), 64'd5);
    tick();
    chk("bp_idle_read", 64'(read), 64'd0);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    read_ready = 1'b0;

    // enable dropped in PROC_WAIT: sample completes, no further reads
    bypass = 1'b0; enable = 1'b1; read_ready = 1'b1; proc_ready = 1'b1;
    readdata_left = 24'h0F0F0F; readdata_right = 24'hF0F0F0;
    tick();
    tick();
    chk("dis_wait", 64'(dbg_state), 64'(ST_PROC_WAIT));
    enable = 1'b0;
    reads_before = n_reads;
    res_valid = 1'b1; res_left = 24'h00C0DE; res_right = 24'h00D00D;
    tick();
    res_valid = 1'b0;
    tick();
    chk("dis_write", 64'(write), 64'd1);
    chk("dis_wdl", 64'(writedata_left), 64'h00C0DE);
    chk("dis_scnt", 64'(sample_cnt), 64'd6);
    for (int i = 0; i < 5; i++) tick();
    chk("dis_no_reads", 64'(n_reads), 64'(reads_before));
    chk("dis_busy", 64'(busy), 64'd0);
    read_ready = 1'b0;

    // reset asserted while waiting in WRITE
    write_ready = 1'b0; bypass = 1'b1; enable = 1'b1; read_ready = 1'b1;
    readdata_left = 24'hDEADBE; readdata_right = 24'hEFCAFE;
    tick();
    chk("rw_state", 64'(dbg_state), 64'(ST_WRITE));
    enable = 1'b0; read_ready = 1'b0;
    writes_before = n_writes;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rw");
    chk("rw_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    write_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rw_no_write", 64'(n_writes), 64'(writes_before));
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_scnt", 64'(sample_cnt), 64'd0);

    // repeated fallbacks: timeout_cnt saturates, sample_cnt wraps
    bypass = 1'b0; proc_ready = 1'b1; write_ready = 1'b1;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      enable = 1'b1; read_ready = 1'b1;
      readdata_left = SW'(i + 16); readdata_right = SW'(i + 32);
      tick();
      enable = 1'b0; read_ready = 1'b0;
      tick();
      for (int j = 0; j < TO; j++) tick();
      chk("sat_wdl", 64'(writedata_left), 64'(i + 16));
      tick();
      exp_to = (i + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : i + 1;
      chk("sat_tcnt", 64'(timeout_cnt), 64'(exp_to));
      chk("sat_scnt", 64'(sample_cnt), 64'((i + 1) % (1 << CW)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
